// File: rtl/score_bcd_digits_pkg.sv
// Shared types and helpers for the score-to-BCD digit feeder.
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN.
package score_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_HOLD
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Integer power of ten, evaluated at elaboration to size the saturation limit.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/score_bcd_digits_double_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// accumulator left by one bit, pulling in the next binary bit at the bottom.
module double_dabble_step
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] acc,
  input  logic                    bit_in,
  output logic [4*NUM_DIGITS-1:0] acc_next
);

  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

  logic [4*NUM_DIGITS-1:0] adjusted;

  // Per-digit correction followed by the one-bit shift.
  always_comb begin
    // NOTE: default assignment first so no path leaves adjusted unassigned (no latch).
    adjusted = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adjusted[4*i +: 4] = add3(acc[4*i +: 4]);
    end
    acc_next = {adjusted[4*NUM_DIGITS-2:0], bit_in};
  end

endmodule

// File: rtl/score_bcd_digits.sv
// Binary score to packed BCD digits, one bit per cycle, committed to the
// outputs only at a frame boundary so the digit sprites see a stable value.
// Macro LEADING_ZERO_BLANK_EN enables the leading-zero blank flags;
// without it digit_blank_out is tied to zero.
module score_bcd_digits
  import score_pkg::*;
#(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_n_in,
  input  logic [BIN_WIDTH-1:0]    score_in,
  input  logic                    score_valid_in,
  input  logic                    frame_start_in,
  output logic                    busy_out,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_blank_out,
  output logic                    overflow_out
);

  localparam int ACC_W   = 4 * NUM_DIGITS;
  localparam int MAX_VAL = pow10(NUM_DIGITS) - 1;
  localparam int CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  // Wide enough that neither the score nor the limit is truncated in the compare.
  localparam int CMP_W   = BIN_WIDTH + 32;

  localparam logic [CMP_W-1:0] MAX_EXT       = CMP_W'(unsigned'(MAX_VAL));
  localparam logic [CMP_W-1:0] SCORE_TOP_EXT = CMP_W'({BIN_WIDTH{1'b1}});
  // When the input range cannot exceed the limit, saturation logic folds away.
  localparam bit               OVF_POSSIBLE  = (SCORE_TOP_EXT > MAX_EXT);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BIN_WIDTH - 1);

  state_t               state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_pend;
  logic                 slot_full;
  logic [BIN_WIDTH-1:0] slot_val;
  logic                 slot_ovf;

  logic [CMP_W-1:0]     score_ext;
  logic                 req_ovf;
  logic [BIN_WIDTH-1:0] req_val;
  logic                 commit;

  assign score_ext = CMP_W'(score_in);
  assign req_ovf   = OVF_POSSIBLE && (score_ext > MAX_EXT);
  assign req_val   = req_ovf ? MAX_EXT[BIN_WIDTH-1:0] : score_in;
  assign commit    = (state == ST_HOLD) && frame_start_in;

  double_dabble_step #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_step (
    .acc      (acc),
    .bit_in   (shreg[BIN_WIDTH-1]),
    .acc_next (acc_next)
  );

  // Conversion FSM with registered busy, digit and overflow outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state        <= ST_IDLE;
      shreg        <= '0;
      acc          <= '0;
      cnt          <= '0;
      ovf_pend     <= 1'b0;
      slot_full    <= 1'b0;
      slot_val     <= '0;
      slot_ovf     <= 1'b0;
      busy_out     <= 1'b0;
      digits_out   <= '0;
      overflow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (score_valid_in) begin
            shreg    <= req_val;
            ovf_pend <= req_ovf;
            acc      <= '0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= ST_CONVERT;
          end
        end

        ST_CONVERT: begin
          acc   <= acc_next;
          shreg <= {shreg[BIN_WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          // Later requests overwrite the one-deep slot.
          if (score_valid_in) begin
            slot_full <= 1'b1;
            slot_val  <= req_val;
            slot_ovf  <= req_ovf;
          end
          if (cnt == CNT_LAST) begin
            if (score_valid_in || slot_full) begin
              // A newer score is waiting: drop this result and start over.
              shreg     <= score_valid_in ? req_val : slot_val;
              ovf_pend  <= score_valid_in ? req_ovf : slot_ovf;
              acc       <= '0;
              cnt       <= '0;
              slot_full <= 1'b0;
            end else begin
              busy_out <= 1'b0;
              state    <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (commit) begin
            digits_out   <= acc;
            overflow_out <= ovf_pend;
          end
          if (score_valid_in) begin
            shreg    <= req_val;
            ovf_pend <= req_ovf;
            acc      <= '0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= ST_CONVERT;
          end else if (frame_start_in) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i (i >= 1) blanks when it and every higher digit are zero.
  function automatic logic [NUM_DIGITS-1:0] calc_blank(input logic [ACC_W-1:0] d);
    logic [NUM_DIGITS-1:0] b;
    logic                  zero_above;
    b          = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      b[i]       = zero_above;
    end
    return b;
  endfunction

  // Blank flags commit together with the digits.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      digit_blank_out <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else if (commit) begin
      digit_blank_out <= calc_blank(acc);
    end
  end
`else
  assign digit_blank_out = '0;
`endif

endmodule

// File: tb/tb_score_bcd_digits.sv
// Directed bench for score_bcd_digits with hand-computed BCD results.
// Honors LEADING_ZERO_BLANK_EN for the expected blank flags.
module tb_score_bcd_digits;

  logic        pixel_clk_in;
  logic        rst_n_in;
  logic [13:0] score_in;
  logic        score_valid_in;
  logic        frame_start_in;
  logic        busy_out;
  logic [15:0] digits_out;
  logic [3:0]  digit_blank_out;
  logic        overflow_out;

  int n_checks = 0;
  int n_fail   = 0;

  score_bcd_digits #(
    .BIN_WIDTH  (14),
    .NUM_DIGITS (4)
  ) dut (
    .pixel_clk_in    (pixel_clk_in),
    .rst_n_in        (rst_n_in),
    .score_in        (score_in),
    .score_valid_in  (score_valid_in),
    .frame_start_in  (frame_start_in),
    .busy_out        (busy_out),
    .digits_out      (digits_out),
    .digit_blank_out (digit_blank_out),
    .overflow_out    (overflow_out)
  );

  initial pixel_clk_in = 1'b0;
  always #5 pixel_clk_in = ~pixel_clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_blank(input logic [3:0] b);
`ifdef LEADING_ZERO_BLANK_EN
    return b;
`else
    return 4'b0000;
`endif
  endfunction

  // One-cycle score request; returns on the negedge where valid drops.
  task automatic pulse_score(input logic [13:0] v);
    @(negedge pixel_clk_in);
    score_in       = v;
    score_valid_in = 1'b1;
    @(negedge pixel_clk_in);
    score_valid_in = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start_in = 1'b1;
    @(negedge pixel_clk_in);
    frame_start_in = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; digits must stay put meanwhile.
  task automatic wait_busy(input string tag, input int exp_cycles, input logic [15:0] held);
    int n;
    logic moved;
    n     = 0;
    moved = 1'b0;
    while (busy_out && n < 200) begin
      if (digits_out !== held) moved = 1'b1;
      n++;
      @(negedge pixel_clk_in);
    end
    check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_digits_held"}, moved, 1'b0);
  endtask

  task automatic convert_commit(input string tag, input logic [13:0] v, input logic [15:0] held);
    pulse_score(v);
    wait_busy(tag, 14, held);
    repeat (3) @(negedge pixel_clk_in);
    check({tag, "_no_commit_before_frame"}, digits_out, held);
    pulse_frame();
  endtask

  initial begin
    int n;
    logic moved;
    rst_n_in       = 1'b0;
    score_in       = '0;
    score_valid_in = 1'b0;
    frame_start_in = 1'b0;
    repeat (3) @(negedge pixel_clk_in);
    rst_n_in = 1'b1;
    @(negedge pixel_clk_in);

    check("reset_digits", digits_out, 16'h0000);
    check("reset_blank", digit_blank_out, exp_blank(4'b1110));
    check("reset_busy", busy_out, 1'b0);
    check("reset_ovf", overflow_out, 1'b0);

    convert_commit("s1234", 14'd1234, 16'h0000);
    check("s1234_digits", digits_out, 16'h1234);
    check("s1234_blank", digit_blank_out, exp_blank(4'b0000));
    check("s1234_ovf", overflow_out, 1'b0);

    // Frame pulse on the completion cycle must not commit.
    pulse_score(14'd7);
    repeat (13) @(negedge pixel_clk_in);
    pulse_frame();
    check("s7_busy_done", busy_out, 1'b0);
    check("s7_early_frame_ignored", digits_out, 16'h1234);
    repeat (2) @(negedge pixel_clk_in);
    pulse_frame();
    check("s7_digits", digits_out, 16'h0007);
    check("s7_blank", digit_blank_out, exp_blank(4'b1110));

    convert_commit("s12000", 14'd12000, 16'h0007);
    check("s12000_digits", digits_out, 16'h9999);
    check("s12000_ovf", overflow_out, 1'b1);
    check("s12000_blank", digit_blank_out, exp_blank(4'b0000));

    convert_commit("s42", 14'd42, 16'h9999);
    check("s42_digits", digits_out, 16'h0042);
    check("s42_ovf", overflow_out, 1'b0);
    check("s42_blank", digit_blank_out, exp_blank(4'b1100));

    // 100 then 250 five cycles later: only 250 may ever be committed.
    pulse_score(14'd100);
    n     = 0;
    moved = 1'b0;
    while (busy_out && n < 200) begin
      if (digits_out !== 16'h0042) moved = 1'b1;
      n++;
      if (n == 5) begin
        score_in       = 14'd250;
        score_valid_in = 1'b1;
      end else begin
        score_valid_in = 1'b0;
      end
      @(negedge pixel_clk_in);
    end
    score_valid_in = 1'b0;
    check("s250_busy_cycles", n, 28);
    check("s250_digits_held", moved, 1'b0);
    repeat (2) @(negedge pixel_clk_in);
    pulse_frame();
    check("s250_digits", digits_out, 16'h0250);
    check("s250_blank", digit_blank_out, exp_blank(4'b1000));

    convert_commit("s5678", 14'd5678, 16'h0250);
    check("s5678_digits", digits_out, 16'h5678);

    // Asynchronous reset in the middle of a conversion.
    pulse_score(14'd321);
    repeat (3) @(negedge pixel_clk_in);
    check("rst_busy_before", busy_out, 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_async_digits", digits_out, 16'h0000);
    check("rst_async_busy", busy_out, 1'b0);
    check("rst_async_blank", digit_blank_out, exp_blank(4'b1110));
    @(negedge pixel_clk_in);
    rst_n_in = 1'b1;
    repeat (16) @(negedge pixel_clk_in);
    pulse_frame();
    repeat (2) @(negedge pixel_clk_in);
    check("rst_no_commit_digits", digits_out, 16'h0000);
    check("rst_no_commit_busy", busy_out, 1'b0);
    check("rst_no_commit_ovf", overflow_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
